// File: rtl/lane_evt_pkg.sv
// Shared types and helpers for the lane event collector and its lane arbiters.
// Holds width helpers, the lane index type and the output-stage state encoding.
package lane_evt_pkg;

    // Index width that never collapses to zero bits, even for a single lane.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Largest value a saturating counter of cnt_w bits can hold.
    function automatic longint unsigned drop_sat(input int cnt_w);
        longint unsigned one;
        one = 1;
        return (one << cnt_w) - one;
    endfunction

    localparam int DEF_WID = 5;

    typedef logic [clog2_min1(DEF_WID)-1:0] lane_idx_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/lane_event_collector_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Searches a doubled request vector masked below ptr, so the wrap needs no second pass.
module rr_pick
    import lane_evt_pkg::*;
#(
    parameter int WID   = 5,
    parameter int IDX_W = clog2_min1(WID)
) (
    input  logic [WID-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [2*WID-1:0] dbl_req;
    logic             found;

    assign dbl_req = {req, req};
    assign any     = |req;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        for (int j = 0; j < 2*WID; j++) begin
            if (!found && dbl_req[j] && (j >= int'(ptr))) begin
                found   = 1'b1;
                gnt_idx = (j >= WID) ? IDX_W'(j - WID) : IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/lane_event_collector.sv
// Collects rising edges on per-lane level inputs, queues one event per lane and
// serialises them round-robin into a lane-index stream with a valid/ready handshake.
module lane_event_collector
    import lane_evt_pkg::*;
#(
    parameter int WID   = 5,
    parameter int IDX_W = clog2_min1(WID),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WID-1:0]   lane_in,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_lane,
    input  logic             evt_ready,
    output logic [WID-1:0]   pending,
    output logic [CNT_W-1:0] drop_count
);

    localparam int NDROP_W = clog2_min1(WID + 1);
    localparam int SUM_W   = CNT_W + NDROP_W;
    localparam logic [SUM_W-1:0] SAT_EXT = SUM_W'(drop_sat(CNT_W));

    out_state_e       state_q, state_d;
    logic [WID-1:0]   prev_in_q, pending_q, pending_d;
    logic [WID-1:0]   rise, take_mask, drops;
    logic [IDX_W-1:0] evt_lane_q, evt_lane_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any, load;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [NDROP_W-1:0] ndrop;
    logic [SUM_W-1:0] drop_sum;

    rr_pick #(
        .WID   (WID),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (pending_q),
        .ptr     (rr_ptr_q),
        .gnt_idx (sel_idx),
        .any     (sel_any)
    );

    assign rise = lane_in & ~prev_in_q;
    assign load = ((state_q == EMPTY) || evt_ready) && sel_any;

    // A rise on a lane whose bit is being taken this cycle re-queues rather than drops.
    always_comb begin
        take_mask = '0;
        if (load) begin
            take_mask[sel_idx] = 1'b1;
        end
        pending_d = (pending_q & ~take_mask) | rise;
        drops     = rise & pending_q & ~take_mask;

        ndrop = '0;
        for (int i = 0; i < WID; i++) begin
            ndrop = ndrop + NDROP_W'(drops[i]);
        end
        drop_sum = SUM_W'(drop_q) + SUM_W'(ndrop);
        drop_d   = (drop_sum > SAT_EXT) ? '1 : drop_sum[CNT_W-1:0];
    end

    // Output stage: reload whenever the slot is empty or being drained.
    always_comb begin
        state_d    = state_q;
        evt_lane_d = evt_lane_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) begin
            state_d    = FULL;
            evt_lane_d = sel_idx;
            rr_ptr_d   = (sel_idx == IDX_W'(WID - 1)) ? '0 : sel_idx + 1'b1;
        end else if (evt_ready) begin
            state_d = EMPTY;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            prev_in_q  <= '0;
            pending_q  <= '0;
            evt_lane_q <= '0;
            rr_ptr_q   <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            prev_in_q  <= lane_in;
            pending_q  <= pending_d;
            evt_lane_q <= evt_lane_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_q     <= drop_d;
        end
    end

    assign evt_valid  = (state_q == FULL);
    assign evt_lane   = evt_lane_q;
    assign pending    = pending_q;
    assign drop_count = drop_q;

endmodule

// File: doc/lane_event_collector.md
Name: lane_event_collector

Overview:
- Receiving end of the per-lane walking-pulse fabric.
- An initiator drives a WID-wide vector, one bit per generated lane instance, and walks a single 1 across it.
- This block watches every lane for rising edges, queues one pending event per lane, and serialises the events into a single lane-index stream with a valid/ready handshake. It is the one-hot-to-index counterpart of the walking-one driver.
- Sits beside the generated lane array. Its output feeds a single consumer, e.g. a logger or scoreboard.

Parameters:
- WID, 5, number of lanes (>=2).
- IDX_W, $clog2(WID), width of the lane index output.
- CNT_W, 8, width of the saturating dropped-event counter.

Ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous active-low reset.
- lane_in  input  WID  per-lane level inputs, synchronous to clk. Bit i belongs to lane instance i.
- evt_valid  output  1  an event is presented on evt_lane.
- evt_lane  output  IDX_W  index of the lane whose event is presented.
- evt_ready  input  1  consumer accepts the presented event.
- pending  output  WID  events queued but not yet presented.
- drop_count  output  CNT_W  saturating count of events lost to overflow.

Behaviour:
- Reset: asserting rst_n low immediately clears prev_in, pending, evt_valid, evt_lane, rr_ptr and drop_count. This holds even mid-transfer. Any queued or presented event is discarded and is not counted as a drop.
- Edge detect: prev_in registers lane_in every cycle. rise[i] = lane_in[i] & ~prev_in[i]. prev_in resets to 0, so a lane held high through reset release produces one rise on the first clk edge.
- Queue: each lane holds at most one pending event.
  - rise[i] sets pending[i] at the next clk edge.
  - If pending[i] is already set and is not being taken this cycle, the new rise is dropped and drop_count increments.
  - drop_count saturates at 2^CNT_W-1.
  - Several lanes dropping in one cycle add their count, saturating.
- Take condition: load = (~evt_valid | evt_ready) & (pending != 0).
  - When load is true, select the first set pending bit at or after rr_ptr, wrapping past WID-1 to 0.
  - That index goes to evt_lane, evt_valid is set, and that pending bit is cleared.
  - rr_ptr becomes sel+1, wrapping WID-1 -> 0.
- Simultaneous take and rise on the same lane: set wins. pending[i] stays 1, the new event is queued and nothing is dropped.
- Handshake:
  - evt_valid & evt_ready completes a transfer.
  - If no pending event exists at that edge, evt_valid falls.
  - While evt_valid=1 and evt_ready=0, evt_lane is held stable.
  - Back-to-back transfers run one per cycle.
- Latency: a rise sampled at edge k sets pending at edge k. With the output free, evt_valid and evt_lane appear after edge k+1.
- Only pending-but-unpresented events live in `pending`. The presented event is not double-counted.
- Fairness: with all lanes continuously pending and evt_ready=1, each lane is presented once every WID cycles.
- No other state. Control is a 2-state output FSM (EMPTY, FULL) plus the rr_ptr counter.

Decomposition:
- Shared package `lane_evt_pkg` holds:
  - function clog2_min1 (returns at least 1);
  - typedef for the lane index;
  - DROP_SAT constant derivation helper.
- One natural sub-module, `rr_pick`: a combinational round-robin priority picker with inputs req[WID] and ptr[IDX_W], and outputs gnt_idx and any.
  - Implement it as a doubled-vector mask search.
  - Reuse it for any later lane arbiters.

Test Plan:
- Walking one: WID=5, lane_in starts 0, then 00001, 00010, 00100, 01000, 10000, 00000, one cycle each, evt_ready=1. Required: evt_lane = 0,1,2,3,4 on consecutive cycles, each appearing 2 edges after its lane rises. drop_count=0. pending=0 at end.
- Simultaneous: all 5 lanes rise in one cycle with evt_ready=1 and rr_ptr=0. Required: evt_lane 0,1,2,3,4 on 5 consecutive cycles, then evt_valid=0.
- Backpressure and drop: lane 2 rises, then evt_ready=0 for 6 cycles while lane 2 pulses twice more. Required: evt_lane=2 held stable. The first extra pulse queues (pending=00100). The second is dropped (drop_count=1). Releasing ready yields exactly two lane-2 transfers.
- Round-robin wrap: rr_ptr=3 (after serving lane 2), then lanes 0 and 4 rise together. Required order is 4 then 0.
- Set-wins: lane 1 rises in the same cycle its pending bit is taken. Required: pending[1] stays 1, drop_count unchanged, and two lane-1 transfers in total.
- Reset mid-operation: with evt_valid=1 and pending=10110, pulse rst_n low between clk edges. Required: all outputs 0 immediately. After release, no stale events appear. Lanes held high through reset release produce exactly one event each.
